// File: rtl/udp_mode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_mode_pkg
// Description : Shared constants for the UDP mode-switch link. This package
//               holds the command codes, the mode encodings and the receiver
//               FSM state codes. The key-triggered sender uses the same codes.
// Revision    : 1.0 - initial release
// ============================================================================
package udp_mode_pkg;

    // Command words carried in the 2-byte payload, MSB first
    localparam logic [15:0] CMD_CAM  = 16'h0001;
    localparam logic [15:0] CMD_SD   = 16'h0003;

    // Datapath mux select encodings
    localparam logic [1:0]  MODE_CAM = 2'b01;
    localparam logic [1:0]  MODE_SD  = 2'b11;

    // Receiver FSM state encodings
    localparam int          c_ST_W      = 3;
    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_RECV   = 3'd1;
    localparam logic [2:0]  c_ST_DRAIN  = 3'd2;
    localparam logic [2:0]  c_ST_CHECK  = 3'd3;
    localparam logic [2:0]  c_ST_UPDATE = 3'd4;

    // True when the command word is one of the two recognised codes
    function automatic logic cmd_is_known(input logic [15:0] cmd);
        return (cmd == CMD_CAM) || (cmd == CMD_SD);
    endfunction

    // Mode select implied by a known command word
    function automatic logic [1:0] mode_of_cmd(input logic [15:0] cmd);
        return (cmd == CMD_CAM) ? MODE_CAM : MODE_SD;
    endfunction

endpackage : udp_mode_pkg
`default_nettype wire

// File: rtl/udp_rx_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : udp_rx_gap_timer
// Description : Inter-byte idle counter. Counts cycles while enabled and
//               clears on demand. It flags a timeout once GAP_TIMEOUT idle
//               cycles have been counted. The count saturates at the timeout
//               value so the flag stays stable until the next clear.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_rx_gap_timer #(
    parameter logic [15:0] GAP_TIMEOUT = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    logic [15:0] r_gap_cnt;
    logic        w_at_limit;

    assign w_at_limit = (r_gap_cnt == GAP_TIMEOUT);
    assign o_timeout  = w_at_limit;

    // Idle-cycle counter: clear has priority, then count up to the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt <= 16'd0;
        end else if (i_clear) begin
            r_gap_cnt <= 16'd0;
        end else if (i_enable && !w_at_limit) begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
        end
    end

endmodule : udp_rx_gap_timer
`default_nettype wire

// File: rtl/udp_mode_rx.sv
`default_nettype none
// ============================================================================
// Module      : udp_mode_rx
// Description : Receiver for the 2-byte mode-switch command. It parses the
//               UDP payload stream and validates the length and the command
//               code. It then drives a registered camera / SD-card mode
//               select. Accept, change and error events are single-cycle
//               pulses.
//               Optional macro UDP_MODE_RX_STATS_EN adds good_cnt / bad_cnt
//               wrap-around event counters and their ports.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_mode_rx
    import udp_mode_pkg::*;
#(
    parameter logic [1:0]  DEFAULT_MODE = 2'b01,
    parameter logic [15:0] GAP_TIMEOUT  = 16'd1000,
    parameter logic [15:0] CMD_LEN      = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        app_rx_data_valid,
    input  logic [7:0]  app_rx_data,
    input  logic [15:0] app_rx_data_length,
    output logic [1:0]  mode_sel,
    output logic        mode_update,
    output logic        mode_changed,
    output logic        cmd_err
`ifdef UDP_MODE_RX_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    logic [c_ST_W-1:0] r_state;
    logic [15:0]       r_len;
    logic [15:0]       r_cmd;
    logic [15:0]       r_byte_cnt;
    logic [1:0]        r_mode_sel;
    logic              r_mode_update;
    logic              r_mode_changed;
    logic              r_cmd_err;

    logic              w_in_payload;
    logic              w_gap_clear;
    logic              w_gap_enable;
    logic              w_timeout;
    logic [15:0]       w_next_cnt;
    logic              w_cmd_pass;
    logic [1:0]        w_new_mode;

    // The gap timer only runs between bytes of a packet being received or drained
    assign w_in_payload = (r_state == c_ST_RECV) || (r_state == c_ST_DRAIN);
    assign w_gap_clear  = app_rx_data_valid || !w_in_payload;
    assign w_gap_enable = w_in_payload && !app_rx_data_valid;

    assign w_next_cnt   = r_byte_cnt + 16'd1;
    assign w_cmd_pass   = (r_len == CMD_LEN) && cmd_is_known(r_cmd);
    assign w_new_mode   = mode_of_cmd(r_cmd);

    udp_rx_gap_timer #(
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) u_gap_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_gap_clear),
        .i_enable  (w_gap_enable),
        .o_timeout (w_timeout)
    );

    // Packet FSM, command register, mode select and event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_len          <= 16'd0;
            r_cmd          <= 16'd0;
            r_byte_cnt     <= 16'd0;
            r_mode_sel     <= DEFAULT_MODE;
            r_mode_update  <= 1'b0;
            r_mode_changed <= 1'b0;
            r_cmd_err      <= 1'b0;
        end else begin
            r_mode_update  <= 1'b0;
            r_mode_changed <= 1'b0;
            r_cmd_err      <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (app_rx_data_valid) begin
                        r_len       <= app_rx_data_length;
                        r_cmd[15:8] <= app_rx_data;
                        r_byte_cnt  <= 16'd1;
                        if (app_rx_data_length == 16'd0) begin
                            // Empty payload cannot carry a command: drop it at once
                            r_cmd_err  <= 1'b1;
                            r_byte_cnt <= 16'd0;
                        end else if (app_rx_data_length == 16'd1) begin
                            r_state <= c_ST_CHECK;
                        end else if (app_rx_data_length == CMD_LEN) begin
                            r_state <= c_ST_RECV;
                        end else begin
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end

                c_ST_RECV: begin
                    if (w_timeout) begin
                        r_cmd_err  <= 1'b1;
                        r_byte_cnt <= 16'd0;
                        r_state    <= c_ST_IDLE;
                    end else if (app_rx_data_valid) begin
                        // Low byte slot; a longer CMD_LEN keeps the last byte seen
                        r_cmd[7:0] <= app_rx_data;
                        r_byte_cnt <= w_next_cnt;
                        if (w_next_cnt == r_len) begin
                            r_state <= c_ST_CHECK;
                        end
                    end
                end

                c_ST_DRAIN: begin
                    if (w_timeout) begin
                        r_cmd_err  <= 1'b1;
                        r_byte_cnt <= 16'd0;
                        r_state    <= c_ST_IDLE;
                    end else if (app_rx_data_valid) begin
                        r_byte_cnt <= w_next_cnt;
                        if (w_next_cnt == r_len) begin
                            r_state <= c_ST_CHECK;
                        end
                    end
                end

                c_ST_CHECK: begin
                    r_byte_cnt <= 16'd0;
                    if (app_rx_data_valid) begin
                        // A byte here breaks the inter-packet gap guarantee
                        r_cmd_err <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end else if (w_cmd_pass) begin
                        r_mode_sel     <= w_new_mode;
                        r_mode_update  <= 1'b1;
                        r_mode_changed <= (w_new_mode != r_mode_sel);
                        r_state        <= c_ST_UPDATE;
                    end else begin
                        r_cmd_err <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end
                end

                c_ST_UPDATE: begin
                    // Update pulses are visible this cycle; a stray byte errors one cycle later
                    r_cmd_err <= app_rx_data_valid;
                    r_state   <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign mode_sel     = r_mode_sel;
    assign mode_update  = r_mode_update;
    assign mode_changed = r_mode_changed;
    assign cmd_err      = r_cmd_err;

`ifdef UDP_MODE_RX_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    // Free-running event counters that wrap naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_good_cnt <= 16'd0;
            r_bad_cnt  <= 16'd0;
        end else begin
            if (r_mode_update) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (r_cmd_err) begin
                r_bad_cnt <= r_bad_cnt + 16'd1;
            end
        end
    end

    assign good_cnt = r_good_cnt;
    assign bad_cnt  = r_bad_cnt;
`endif

endmodule : udp_mode_rx
`default_nettype wire

// File: tb/tb_udp_mode_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_mode_rx
// Description : Directed self-checking bench for udp_mode_rx. Each scenario
//               has hand-computed expectations for mode_sel and the event
//               pulses. Inputs change 1 time unit after the rising edge. The
//               same point is used to sample the registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_mode_rx;

    localparam logic [15:0] c_GAP = 16'd1000;

    logic        clk;
    logic        rst;
    logic        app_rx_data_valid;
    logic [7:0]  app_rx_data;
    logic [15:0] app_rx_data_length;
    logic [1:0]  mode_sel;
    logic        mode_update;
    logic        mode_changed;
    logic        cmd_err;
`ifdef UDP_MODE_RX_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
`endif

    int n_checks;
    int n_fail;
    int n_wait;

    udp_mode_rx #(
        .DEFAULT_MODE (2'b01),
        .GAP_TIMEOUT  (c_GAP),
        .CMD_LEN      (16'd2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .app_rx_data_valid  (app_rx_data_valid),
        .app_rx_data        (app_rx_data),
        .app_rx_data_length (app_rx_data_length),
        .mode_sel           (mode_sel),
        .mode_update        (mode_update),
        .mode_changed       (mode_changed),
`ifdef UDP_MODE_RX_STATS_EN
        .good_cnt           (good_cnt),
        .bad_cnt            (bad_cnt),
`endif
        .cmd_err            (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One payload byte consumed on the next rising edge
    task automatic put_byte(input logic [15:0] len, input logic [7:0] data);
        app_rx_data_valid  = 1'b1;
        app_rx_data        = data;
        app_rx_data_length = len;
        tick();
        app_rx_data_valid  = 1'b0;
        app_rx_data        = 8'h00;
        app_rx_data_length = 16'd0;
    endtask

    task automatic check_pulses(input string tag, input logic upd, input logic chg, input logic err);
        check({tag, ".mode_update"},  {31'd0, mode_update},  {31'd0, upd});
        check({tag, ".mode_changed"}, {31'd0, mode_changed}, {31'd0, chg});
        check({tag, ".cmd_err"},      {31'd0, cmd_err},      {31'd0, err});
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        rst                = 1'b1;
        app_rx_data_valid  = 1'b0;
        app_rx_data        = 8'h00;
        app_rx_data_length = 16'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("reset.mode_sel", {30'd0, mode_sel}, 32'h1);
        check_pulses("reset", 1'b0, 1'b0, 1'b0);

        // 1: SD command from camera mode
        tick();
        put_byte(16'd2, 8'h00);
        put_byte(16'd2, 8'h03);
        tick();
        check("t1.mode_sel", {30'd0, mode_sel}, 32'h3);
        check_pulses("t1", 1'b1, 1'b1, 1'b0);
        tick();
        check_pulses("t1_after", 1'b0, 1'b0, 1'b0);

        // 2: repeated SD command
        tick();
        put_byte(16'd2, 8'h00);
        put_byte(16'd2, 8'h03);
        tick();
        check("t2.mode_sel", {30'd0, mode_sel}, 32'h3);
        check_pulses("t2", 1'b1, 1'b0, 1'b0);

        // 3: unknown command code
        tick();
        tick();
        put_byte(16'd2, 8'h00);
        put_byte(16'd2, 8'h05);
        tick();
        check("t3.mode_sel", {30'd0, mode_sel}, 32'h3);
        check_pulses("t3", 1'b0, 1'b0, 1'b1);

        // 4: over-long packet drained to its end
        tick();
        tick();
        put_byte(16'd4, 8'h00);
        put_byte(16'd4, 8'h01);
        check("t4.mid_err", {31'd0, cmd_err}, 32'h0);
        put_byte(16'd4, 8'hAA);
        put_byte(16'd4, 8'hBB);
        check("t4.last_err", {31'd0, cmd_err}, 32'h0);
        tick();
        check("t4.mode_sel", {30'd0, mode_sel}, 32'h3);
        check_pulses("t4", 1'b0, 1'b0, 1'b1);

        // 5: gap timeout after first byte, then a camera command is accepted
        tick();
        tick();
        put_byte(16'd2, 8'h00);
        n_wait = 0;
        while (!cmd_err && n_wait < 3000) begin
            tick();
            n_wait++;
        end
        check("t5.timeout_latency", n_wait, 32'(c_GAP) + 32'd1);
        check("t5.mode_sel_abort", {30'd0, mode_sel}, 32'h3);
        tick();
        put_byte(16'd2, 8'h00);
        put_byte(16'd2, 8'h01);
        tick();
        check("t5.mode_sel", {30'd0, mode_sel}, 32'h1);
        check_pulses("t5", 1'b1, 1'b1, 1'b0);

        // Length 1: goes to CHECK and fails the length test
        tick();
        tick();
        put_byte(16'd1, 8'h00);
        check("len1.early_err", {31'd0, cmd_err}, 32'h0);
        tick();
        check_pulses("len1", 1'b0, 1'b0, 1'b1);

        // Length 0: byte discarded, error the very next cycle
        tick();
        tick();
        put_byte(16'd0, 8'h07);
        check_pulses("len0", 1'b0, 1'b0, 1'b1);
        tick();
        check_pulses("len0_after", 1'b0, 1'b0, 1'b0);

        // Byte arriving during CHECK is a protocol violation
        tick();
        put_byte(16'd2, 8'h00);
        put_byte(16'd2, 8'h03);
        put_byte(16'd2, 8'h03);
        check("viol.mode_sel", {30'd0, mode_sel}, 32'h1);
        check_pulses("viol", 1'b0, 1'b0, 1'b1);

        // Move to SD mode so the reset below has something to undo
        tick();
        tick();
        put_byte(16'd2, 8'h00);
        put_byte(16'd2, 8'h03);
        tick();
        check("pre6.mode_sel", {30'd0, mode_sel}, 32'h3);
`ifdef UDP_MODE_RX_STATS_EN
        tick();
        check("stats.good_cnt", {16'd0, good_cnt}, 32'd4);
        check("stats.bad_cnt",  {16'd0, bad_cnt},  32'd6);
`endif

        // 6: reset in the middle of a packet
        tick();
        put_byte(16'd2, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6.mode_sel", {30'd0, mode_sel}, 32'h1);
        check_pulses("t6", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_pulses("t6_after", 1'b0, 1'b0, 1'b0);
`ifdef UDP_MODE_RX_STATS_EN
        check("t6.good_cnt", {16'd0, good_cnt}, 32'd0);
        check("t6.bad_cnt",  {16'd0, bad_cnt},  32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got stall expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_udp_mode_rx
`default_nettype wire
